// File: rtl/rv_intr_gateway.sv
// -----------------------------------------------------------------------------
// rv_intr_gateway
//
// Small interrupt gateway. Each source runs a three-state lifecycle
// (IDLE -> PENDING -> CLAIMED -> IDLE). Pending sources are filtered by
// enable and threshold, then arbitrated by priority. The winner is presented
// to the core as a registered request and ID. Source IDs are index + 1, and
// ID 0 means "no source".
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   intr_src_i     raw interrupt lines, one per source
//   edge_i         per source: 1 = rising-edge triggered, 0 = level triggered
//   ie_i           per-source enable (masks arbitration only, not pending)
//   prio_i         per-source priority, source k at [k*PrioW +: PrioW]
//   threshold_i    only priorities strictly above this value interrupt
//   claim_i        claim strobe: returns the presented ID and claims it
//   complete_i     completion strobe for complete_id_i
//   complete_id_i  ID being completed (0 or out-of-range IDs are ignored)
//   irq_o          registered interrupt request
//   irq_id_o       registered ID of the best candidate, 0 when none
//   claim_id_o     ID returned by the most recent claim
//   ip_o           per-source pending bits
// -----------------------------------------------------------------------------
module rv_intr_gateway #(
    parameter  int NumSrc = 4,
    parameter  int PrioW  = 2,
    localparam int IdW    = $clog2(NumSrc + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumSrc-1:0]       intr_src_i,
    input  logic [NumSrc-1:0]       edge_i,
    input  logic [NumSrc-1:0]       ie_i,
    input  logic [NumSrc*PrioW-1:0] prio_i,
    input  logic [PrioW-1:0]        threshold_i,
    input  logic                    claim_i,
    input  logic                    complete_i,
    input  logic [IdW-1:0]          complete_id_i,
    output logic                    irq_o,
    output logic [IdW-1:0]          irq_id_o,
    output logic [IdW-1:0]          claim_id_o,
    output logic [NumSrc-1:0]       ip_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPending = 2'd1,
        StClaimed = 2'd2
    } src_state_e;

    src_state_e        src_state_p0 [NumSrc];
    src_state_e        src_state_d  [NumSrc];
    logic [NumSrc-1:0] prev_sample_p0;

    logic [NumSrc-1:0] trigger;
    logic [NumSrc-1:0] claim_hit;
    logic [NumSrc-1:0] complete_hit;
    logic [NumSrc-1:0] pending;
    logic [NumSrc-1:0] cand;

    logic              best_found;
    logic [PrioW-1:0]  best_prio;
    logic [IdW-1:0]    best_id;

    // Trigger and strobe decode. Claim targets whatever ID is currently
    // presented on irq_id_o; IDs 0 and above NumSrc match no source, so such
    // claims and completes fall through without effect.
    always_comb begin
        trigger      = '0;
        claim_hit    = '0;
        complete_hit = '0;
        for (int k = 0; k < NumSrc; k++) begin
            trigger[k]      = edge_i[k] ? (intr_src_i[k] & ~prev_sample_p0[k])
                                        : intr_src_i[k];
            claim_hit[k]    = claim_i    && (irq_id_o      == IdW'(k + 1));
            complete_hit[k] = complete_i && (complete_id_i == IdW'(k + 1));
        end
    end

    // Source FSM state register and edge-detect history. The history resets to
    // 0, so a line already high when reset is released counts as an edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumSrc; k++) begin
                src_state_p0[k] <= StIdle;
            end
            prev_sample_p0 <= '0;
        end else begin
            for (int k = 0; k < NumSrc; k++) begin
                src_state_p0[k] <= src_state_d[k];
            end
            prev_sample_p0 <= intr_src_i;
        end
    end

    // Source FSM next state. Triggers seen outside IDLE are simply dropped.
    // A complete aimed at a source that is being claimed this cycle finds it
    // still PENDING and is therefore ignored.
    always_comb begin
        for (int k = 0; k < NumSrc; k++) begin
            src_state_d[k] = src_state_p0[k];
            case (src_state_p0[k])
                StIdle: begin
                    if (trigger[k]) begin
                        src_state_d[k] = StPending;
                    end
                end
                StPending: begin
                    if (claim_hit[k]) begin
                        src_state_d[k] = StClaimed;
                    end
                end
                StClaimed: begin
                    if (complete_hit[k]) begin
                        src_state_d[k] = StIdle;
                    end
                end
                default: begin
                    src_state_d[k] = StIdle;
                end
            endcase
        end
    end

    // Source FSM outputs: pending bits straight from the state.
    always_comb begin
        for (int k = 0; k < NumSrc; k++) begin
            pending[k] = (src_state_p0[k] == StPending);
        end
    end

    assign ip_o = pending;

    // Candidate filter and arbitration. The strict '>' keeps the lowest index
    // on ties; priority 0 can never exceed a threshold and so never wins.
    always_comb begin
        cand       = '0;
        best_found = 1'b0;
        best_prio  = '0;
        best_id    = '0;
        for (int k = 0; k < NumSrc; k++) begin
            cand[k] = pending[k] && ie_i[k] &&
                      (prio_i[k*PrioW +: PrioW] > threshold_i);
            if (cand[k] && (!best_found || (prio_i[k*PrioW +: PrioW] > best_prio))) begin
                best_found = 1'b1;
                best_prio  = prio_i[k*PrioW +: PrioW];
                best_id    = IdW'(k + 1);
            end
        end
    end

    // Output stage: request and ID lag ip_o by one cycle; claim_id_o holds
    // until the next claim.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o      <= 1'b0;
            irq_id_o   <= '0;
            claim_id_o <= '0;
        end else begin
            irq_o    <= best_found;
            irq_id_o <= best_id;
            if (claim_i) begin
                claim_id_o <= irq_id_o;
            end
        end
    end

endmodule
